// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: sequencing arbiter for the shared ROM/RAM bus.
// Three requesters (ROM fetch, RAM read, RAM write) are granted one at a
// time. Each grant runs through a fixed number of wait states and ends with
// a one-cycle acknowledge. Every bus-facing output comes from a flop.
//
// Build option: define MEM_BUS_ARB_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority fetch > rd > wr.
module mem_bus_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int ROM_WAIT = 1,
   parameter int RAM_WAIT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ack,
   output logic [DATA_W-1:0] fetch_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              rom_en,
   output logic              ram_re,
   output logic              ram_we,
   input  logic [DATA_W-1:0] rom_q,
   input  logic [DATA_W-1:0] ram_q,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Requester codes double as bit positions in the request vector.
   localparam logic [1:0] SRC_FETCH = 2'd0;
   localparam logic [1:0] SRC_RD    = 2'd1;
   localparam logic [1:0] SRC_WR    = 2'd2;

   localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
   localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

   // First requester that is asking, in the search order a, b, c.
   // Returns {valid, code}.
   function automatic logic [2:0] pick3(input logic [2:0] req_v,
                                        input logic [1:0] a,
                                        input logic [1:0] b,
                                        input logic [1:0] c);
      logic [2:0] res;
      if (req_v[a]) begin
         res = {1'b1, a};
      end else if (req_v[b]) begin
         res = {1'b1, b};
      end else if (req_v[c]) begin
         res = {1'b1, c};
      end else begin
         res = 3'b000;
      end
      return res;
   endfunction

   state_t            state_q, state_d;
   logic [1:0]        winner_q, winner_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              rom_en_q, rom_en_d;
   logic              ram_re_q, ram_re_d;
   logic              ram_we_q, ram_we_d;
   logic              fetch_ack_q, fetch_ack_d;
   logic              rd_ack_q, rd_ack_d;
   logic              wr_ack_q, wr_ack_d;
   logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              busy_q, busy_d;

   logic [2:0]        req_v_s;
   logic [2:0]        pick_s;
   logic              grant_vld_s;
   logic [1:0]        grant_src_s;

`ifdef MEM_BUS_ARB_RR_EN
   // Last granted requester; the search starts just after it.
   logic [1:0]        ptr_q, ptr_d;
`endif

   assign req_v_s = {wr_req, rd_req, fetch_req};

   // Choose the requester that wins if the bus is idle this cycle
   always_comb begin
`ifdef MEM_BUS_ARB_RR_EN
      case (ptr_q)
         SRC_FETCH: pick_s = pick3(req_v_s, SRC_RD, SRC_WR, SRC_FETCH);
         SRC_RD:    pick_s = pick3(req_v_s, SRC_WR, SRC_FETCH, SRC_RD);
         SRC_WR:    pick_s = pick3(req_v_s, SRC_FETCH, SRC_RD, SRC_WR);
         default:   pick_s = pick3(req_v_s, SRC_RD, SRC_WR, SRC_FETCH);
      endcase
`else
      pick_s = pick3(req_v_s, SRC_FETCH, SRC_RD, SRC_WR);
`endif
      grant_vld_s = pick_s[2];
      grant_src_s = pick_s[1:0];
   end

   // Next-state and next-output logic for the transfer sequencer
   always_comb begin
      state_d      = state_q;
      winner_d     = winner_q;
      cnt_d        = cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      rom_en_d     = 1'b0;
      ram_re_d     = 1'b0;
      ram_we_d     = 1'b0;
      fetch_ack_d  = 1'b0;
      rd_ack_d     = 1'b0;
      wr_ack_d     = 1'b0;
      fetch_data_d = fetch_data_q;
      rd_data_d    = rd_data_q;
`ifdef MEM_BUS_ARB_RR_EN
      ptr_d        = ptr_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (grant_vld_s) begin
               // Latch operands at grant; later changes are ignored.
               state_d  = ST_ACCESS;
               winner_d = grant_src_s;
`ifdef MEM_BUS_ARB_RR_EN
               ptr_d    = grant_src_s;
`endif
               case (grant_src_s)
                  SRC_FETCH: begin
                     cnt_d       = ROM_WAIT_C;
                     mem_addr_d  = fetch_addr;
                     mem_wdata_d = {DATA_W{1'b0}};
                     rom_en_d    = 1'b1;
                  end
                  SRC_RD: begin
                     cnt_d       = RAM_WAIT_C;
                     mem_addr_d  = rd_addr;
                     mem_wdata_d = {DATA_W{1'b0}};
                     ram_re_d    = 1'b1;
                  end
                  SRC_WR: begin
                     cnt_d       = RAM_WAIT_C;
                     mem_addr_d  = wr_addr;
                     mem_wdata_d = wr_data;
                     ram_we_d    = 1'b1;
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               // Last access cycle: capture read data and acknowledge.
               state_d     = ST_DONE;
               mem_wdata_d = {DATA_W{1'b0}};
               case (winner_q)
                  SRC_FETCH: begin
                     fetch_ack_d  = 1'b1;
                     fetch_data_d = rom_q;
                  end
                  SRC_RD: begin
                     rd_ack_d  = 1'b1;
                     rd_data_d = ram_q;
                  end
                  SRC_WR: begin
                     wr_ack_d = 1'b1;
                  end
                  default: begin
                     fetch_ack_d = 1'b0;
                  end
               endcase
            end else begin
               cnt_d    = cnt_q - 4'd1;
               rom_en_d = rom_en_q;
               ram_re_d = ram_re_q;
               ram_we_d = ram_we_q;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, latched operands and registered bus outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         winner_q     <= SRC_FETCH;
         cnt_q        <= 4'd0;
         mem_addr_q   <= {ADDR_W{1'b0}};
         mem_wdata_q  <= {DATA_W{1'b0}};
         rom_en_q     <= 1'b0;
         ram_re_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         fetch_ack_q  <= 1'b0;
         rd_ack_q     <= 1'b0;
         wr_ack_q     <= 1'b0;
         fetch_data_q <= {DATA_W{1'b0}};
         rd_data_q    <= {DATA_W{1'b0}};
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         winner_q     <= winner_d;
         cnt_q        <= cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         rom_en_q     <= rom_en_d;
         ram_re_q     <= ram_re_d;
         ram_we_q     <= ram_we_d;
         fetch_ack_q  <= fetch_ack_d;
         rd_ack_q     <= rd_ack_d;
         wr_ack_q     <= wr_ack_d;
         fetch_data_q <= fetch_data_d;
         rd_data_q    <= rd_data_d;
         busy_q       <= busy_d;
      end
   end

`ifdef MEM_BUS_ARB_RR_EN
   // Round-robin pointer, starting at fetch so rd is favoured first
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= SRC_FETCH;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign fetch_ack  = fetch_ack_q;
   assign fetch_data = fetch_data_q;
   assign rd_ack     = rd_ack_q;
   assign rd_data    = rd_data_q;
   assign wr_ack     = wr_ack_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign rom_en     = rom_en_q;
   assign ram_re     = ram_re_q;
   assign ram_we     = ram_we_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, corner
// sequences, and randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int ROM_W = 1;
   localparam int RAM_W = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       fetch_req, rd_req, wr_req;
   logic [7:0] fetch_addr, rd_addr, wr_addr, wr_data;
   logic       fetch_ack, rd_ack, wr_ack;
   logic [7:0] fetch_data, rd_data;
   logic [7:0] mem_addr, mem_wdata;
   logic       rom_en, ram_re, ram_we, busy;
   logic [7:0] rom_q, ram_q;

   // Second instance with zero wait states (fetch only)
   logic       f0_req;
   logic [7:0] f0_addr;
   logic       w0_fetch_ack, w0_rd_ack, w0_wr_ack;
   logic [7:0] w0_fetch_data, w0_rd_data, w0_mem_addr, w0_mem_wdata, w0_rom_q;
   logic       w0_rom_en, w0_ram_re, w0_ram_we, w0_busy;

   logic [7:0] ram [256];
   logic       ram_clr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign rom_q    = mem_addr ^ 8'hB5;
   assign ram_q    = ram[mem_addr];
   assign w0_rom_q = w0_mem_addr ^ 8'hB5;

   // RAM device model
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hC3;
      end else if (ram_we) begin
         ram[mem_addr] <= mem_wdata;
      end
   end

   mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .rom_en(rom_en), .ram_re(ram_re), .ram_we(ram_we),
      .rom_q(rom_q), .ram_q(ram_q), .busy(busy)
   );

   mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .ROM_WAIT(0), .RAM_WAIT(0)) dut_w0 (
      .clk(clk), .reset(reset),
      .fetch_req(f0_req), .fetch_addr(f0_addr), .fetch_ack(w0_fetch_ack), .fetch_data(w0_fetch_data),
      .rd_req(1'b0), .rd_addr(8'h00), .rd_ack(w0_rd_ack), .rd_data(w0_rd_data),
      .wr_req(1'b0), .wr_addr(8'h00), .wr_data(8'h00), .wr_ack(w0_wr_ack),
      .mem_addr(w0_mem_addr), .mem_wdata(w0_mem_wdata),
      .rom_en(w0_rom_en), .ram_re(w0_ram_re), .ram_we(w0_ram_we),
      .rom_q(w0_rom_q), .ram_q(8'h00), .busy(w0_busy)
   );

   typedef struct {
      int         src;      // 0 fetch, 1 rd, 2 wr
      logic [7:0] addr;
      logic [7:0] wdata;
      int         exp_en;   // enable cycles
      int         exp_lat;  // edges from sampling edge until ack is seen
      logic [7:0] exp_data; // read data (fetch/rd)
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      ram_clr = 1'b1;
      tick();
      tick();
      reset   = 1'b0;
      ram_clr = 1'b0;
   endtask

   task automatic set_req(input int src, input logic [7:0] a, input logic [7:0] d, input logic v);
      case (src)
         0:       begin fetch_req = v; fetch_addr = a; end
         1:       begin rd_req = v; rd_addr = a; end
         default: begin wr_req = v; wr_addr = a; wr_data = d; end
      endcase
   endtask

   function automatic logic en_of(input int src);
      case (src)
         0:       return rom_en;
         1:       return ram_re;
         default: return ram_we;
      endcase
   endfunction

   function automatic logic ack_of(input int src);
      case (src)
         0:       return fetch_ack;
         1:       return rd_ack;
         default: return wr_ack;
      endcase
   endfunction

   // Issue one transfer from idle and measure enable length, latency, data.
   task automatic run_vec(input string tag, input vec_t v);
      int         en_cnt = 0;
      int         lat = 0;
      logic       bus_ok = 1'b1;
      logic [7:0] dat = 8'h00;
      set_req(v.src, v.addr, v.wdata, 1'b1);
      for (int k = 1; k <= 24 && lat == 0; k++) begin
         tick();
         if (en_of(v.src)) begin
            en_cnt++;
            if (mem_addr !== v.addr) bus_ok = 1'b0;
            if (v.src == 2 && mem_wdata !== v.wdata) bus_ok = 1'b0;
         end
         if (ack_of(v.src)) begin
            lat = k;
            dat = (v.src == 0) ? fetch_data : rd_data;
         end
      end
      set_req(v.src, v.addr, v.wdata, 1'b0);
      check({tag, " en_cycles"}, en_cnt, v.exp_en);
      check({tag, " ack_latency"}, lat, v.exp_lat);
      check({tag, " bus_operands"}, bus_ok, 1'b1);
      if (v.src != 2) check({tag, " read_data"}, dat, v.exp_data);
      tick();
      tick();
   endtask

   // ---------------- transaction-level reference model ----------------
   logic       m_active;
   int         m_src, m_t, m_w, m_last;
   logic [7:0] m_addr, m_wd, exp_fd, exp_rd;
   logic [7:0] ref_ram [256];

   task automatic model_reset();
      m_active = 1'b0;
      m_last   = 0;
      exp_fd   = 8'h00;
      exp_rd   = 8'h00;
      for (int i = 0; i < 256; i++) ref_ram[i] = 8'(i) ^ 8'hC3;
   endtask

   // Advance model by one clock edge using the inputs the DUT will sample.
   task automatic model_step();
      logic [2:0] reqv;
      int         win;
      reqv = {wr_req, rd_req, fetch_req};
      if (m_active) begin
         m_t++;
         if (m_t == m_w + 2) begin
            if (m_src == 0) exp_fd = m_addr ^ 8'hB5;
            if (m_src == 1) exp_rd = ref_ram[m_addr];
         end
         if (m_t > m_w + 2) m_active = 1'b0;
      end else begin
         win = -1;
`ifdef MEM_BUS_ARB_RR_EN
         for (int off = 1; off <= 3; off++)
            if (win < 0 && reqv[(m_last + off) % 3]) win = (m_last + off) % 3;
`else
         for (int i = 0; i < 3; i++)
            if (win < 0 && reqv[i]) win = i;
`endif
         if (win >= 0) begin
            m_active = 1'b1;
            m_src    = win;
            m_last   = win;
            m_t      = 1;
            m_w      = (win == 0) ? ROM_W : RAM_W;
            m_addr   = (win == 0) ? fetch_addr : (win == 1) ? rd_addr : wr_addr;
            m_wd     = (win == 2) ? wr_data : 8'h00;
            if (win == 2) ref_ram[m_addr] = m_wd;
         end
      end
   endtask

   task automatic model_compare();
      logic en_w, ack_w;
      en_w  = m_active && (m_t <= m_w + 1);
      ack_w = m_active && (m_t == m_w + 2);
      check("rnd busy", busy, m_active);
      check("rnd rom_en", rom_en, en_w && m_src == 0);
      check("rnd ram_re", ram_re, en_w && m_src == 1);
      check("rnd ram_we", ram_we, en_w && m_src == 2);
      check("rnd fetch_ack", fetch_ack, ack_w && m_src == 0);
      check("rnd rd_ack", rd_ack, ack_w && m_src == 1);
      check("rnd wr_ack", wr_ack, ack_w && m_src == 2);
      check("rnd fetch_data", fetch_data, exp_fd);
      check("rnd rd_data", rd_data, exp_rd);
      if (en_w) begin
         check("rnd mem_addr", mem_addr, m_addr);
         check("rnd mem_wdata", mem_wdata, m_wd);
      end
   endtask

   initial begin
      int         got[4];
      int         exp_order[4];
      int         nack, rdwr_acks, cnt, en_cnt, lat;
      logic       ok;
      logic [7:0] dat;
      vec_t       v;

      vecs[0] = '{0, 8'h10, 8'h00, ROM_W + 1, ROM_W + 2, 8'hA5};
      vecs[1] = '{2, 8'h20, 8'h3C, RAM_W + 1, RAM_W + 2, 8'h00};
      vecs[2] = '{1, 8'h20, 8'h00, RAM_W + 1, RAM_W + 2, 8'h3C};
      vecs[3] = '{1, 8'h55, 8'h00, RAM_W + 1, RAM_W + 2, 8'h96};
      vecs[4] = '{0, 8'hFF, 8'h00, ROM_W + 1, ROM_W + 2, 8'h4A};
      vecs[5] = '{2, 8'h00, 8'hFF, RAM_W + 1, RAM_W + 2, 8'h00};
      vecs[6] = '{1, 8'h00, 8'h00, RAM_W + 1, RAM_W + 2, 8'hFF};

      fetch_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      fetch_addr = 8'h00; rd_addr = 8'h00; wr_addr = 8'h00; wr_data = 8'h00;
      f0_req = 1'b0; f0_addr = 8'h00;

      // Reset state (checked while reset is still asserted)
      reset = 1'b1;
      ram_clr = 1'b1;
      tick();
      tick();
      check("reset busy", busy, 1'b0);
      check("reset enables", {rom_en, ram_re, ram_we}, 3'b000);
      check("reset acks", {fetch_ack, rd_ack, wr_ack}, 3'b000);
      check("reset mem_addr", mem_addr, 8'h00);
      check("reset mem_wdata", mem_wdata, 8'h00);
      check("reset fetch_data", fetch_data, 8'h00);
      check("reset rd_data", rd_data, 8'h00);
      reset = 1'b0;
      ram_clr = 1'b0;
      tick();

      // Directed single transfers
      for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // All three requests held continuously
      do_reset();
`ifdef MEM_BUS_ARB_RR_EN
      exp_order = '{1, 2, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      got = '{7, 7, 7, 7};
      fetch_addr = 8'h01; rd_addr = 8'h02; wr_addr = 8'h03; wr_data = 8'h44;
      fetch_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
      nack = 0;
      rdwr_acks = 0;
      for (int k = 0; k < 40 && nack < 4; k++) begin
         tick();
         if (rd_ack || wr_ack) rdwr_acks++;
         if (fetch_ack) begin got[nack] = 0; nack++; end
         else if (rd_ack) begin got[nack] = 1; nack++; end
         else if (wr_ack) begin got[nack] = 2; nack++; end
      end
      fetch_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      check("contention ack_count", nack, 4);
      for (int i = 0; i < 4; i++) check($sformatf("grant_order[%0d]", i), got[i], exp_order[i]);
`ifndef MEM_BUS_ARB_RR_EN
      check("starvation rd_wr_acks", rdwr_acks, 0);
`endif
      for (int k = 0; k < 20 && busy; k++) tick();
      check("contention drained", busy, 1'b0);
      tick();

      // Reset during ACCESS of a read
      rd_addr = 8'h40;
      rd_req = 1'b1;
      tick();
      check("pre-reset ram_re", ram_re, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("async reset ram_re", ram_re, 1'b0);
      check("async reset busy", busy, 1'b0);
      rd_req = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (rd_ack) cnt++;
      end
      check("lost transfer rd_ack", cnt, 0);
      v = '{1, 8'h40, 8'h00, RAM_W + 1, RAM_W + 2, 8'h83};
      run_vec("reissue_rd", v);

      // Operands changed and request withdrawn during ACCESS
      rd_addr = 8'h55;
      rd_req = 1'b1;
      tick();
      rd_addr = 8'h56;
      rd_req = 1'b0;
      en_cnt = ram_re ? 1 : 0;
      ok = (mem_addr === 8'h55);
      cnt = 0;
      dat = 8'h00;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (ram_re) begin
            en_cnt++;
            if (mem_addr !== 8'h55) ok = 1'b0;
         end
         if (rd_ack) begin cnt++; dat = rd_data; end
      end
      check("withdraw en_cycles", en_cnt, RAM_W + 1);
      check("withdraw mem_addr", ok, 1'b1);
      check("withdraw ack_count", cnt, 1);
      check("withdraw rd_data", dat, 8'h96);

      // Zero-wait fetch on the second instance
      f0_addr = 8'h33;
      f0_req = 1'b1;
      en_cnt = 0;
      lat = 0;
      dat = 8'h00;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
         tick();
         if (w0_rom_en) en_cnt++;
         if (w0_fetch_ack) begin lat = k; dat = w0_fetch_data; end
      end
      f0_req = 1'b0;
      check("wait0 en_cycles", en_cnt, 1);
      check("wait0 ack_latency", lat, 2);
      check("wait0 fetch_data", dat, 8'h86);

      // Randomized traffic against the reference model
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         model_step();
         tick();
         model_compare();
         if (fetch_ack) fetch_req = 1'b0;
         else if (!fetch_req && $urandom_range(3) == 0) begin
            fetch_req = 1'b1; fetch_addr = 8'($urandom);
         end
         if (rd_ack) rd_req = 1'b0;
         else if (!rd_req && $urandom_range(1) == 0) begin
            rd_req = 1'b1; rd_addr = 8'($urandom);
         end
         if (wr_ack) wr_req = 1'b0;
         else if (!wr_req && $urandom_range(1) == 0) begin
            wr_req = 1'b1; wr_addr = 8'($urandom); wr_data = 8'($urandom);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequencing arbiter for the shared memory bus between the CPU core and the ROM/RAM devices. Accepts three requesters (instruction fetch from ROM, data read from RAM, data write to RAM) and grants exactly one at a time. Runs each granted transfer through a fixed number of wait states, then returns a one-cycle acknowledge to the requester. All bus outputs are registered, so the datapath never sees combinational grant glitches.

## Interface
- ADDR_W, 8, width of all address buses
- DATA_W, 8, width of all data buses
- ROM_WAIT, 1, extra ROM access cycles (0..15)
- RAM_WAIT, 2, extra RAM access cycles (0..15)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_req  in  1  ROM read request; fetch_addr  in  ADDR_W
- fetch_ack  out  1  one-cycle completion pulse; fetch_data  out  DATA_W  valid while fetch_ack=1
- rd_req  in  1  RAM read request; rd_addr  in  ADDR_W
- rd_ack  out  1  completion pulse; rd_data  out  DATA_W  valid while rd_ack=1
- wr_req  in  1  RAM write request; wr_addr  in  ADDR_W; wr_data  in  DATA_W
- wr_ack  out  1  completion pulse
- mem_addr  out  ADDR_W  shared address bus to ROM and RAM
- mem_wdata  out  DATA_W  RAM write data
- rom_en  out  1  ROM read enable
- ram_re  out  1  RAM read enable; ram_we  out  1  RAM write enable
- rom_q  in  DATA_W  ROM read data; ram_q  in  DATA_W  RAM read data
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: sample fetch_req, rd_req, wr_req. If any is high, pick a winner, latch its address (and wr_data), load wait counter with ROM_WAIT or RAM_WAIT, go to ACCESS. Otherwise stay.
- Fixed priority (default): fetch > rd > wr.
- ACCESS: mem_addr = latched address; exactly one of rom_en/ram_re/ram_we high; mem_wdata = latched wr_data for writes, else 0. Counter decrements each cycle; at counter==0, read data (rom_q or ram_q) is captured into the winner's data register and state goes to DONE.
- DONE: all enables low; winner's ack high for exactly one cycle; data output valid. Next state is always IDLE.
- Requester protocol: hold req and operands stable until ack; deassert req at the edge where ack=1 is sampled. A req still high in the following IDLE cycle is a new request.
- Changes on address/data/req during ACCESS are ignored (operands latched at grant). Withdrawn requests still complete and ack.
- fetch_data/rd_data hold their last captured value between acks.

## Timing
- Reset (async, immediate): state IDLE, all acks 0, rom_en/ram_re/ram_we 0, mem_addr 0, mem_wdata 0, fetch_data/rd_data 0, busy 0, RR pointer = fetch.
- Latency: req sampled at edge E0 -> ACCESS for WAIT+1 cycles -> ack high in cycle after edge E0+WAIT+2.
- Enable high for exactly WAIT+1 cycles per transfer; WAIT=0 gives a single-cycle enable.
- Throughput: one transfer per WAIT+3 cycles (IDLE, ACCESS×(WAIT+1), DONE).
- Simultaneous requests: only the winner proceeds; losers are re-evaluated in the next IDLE cycle.
- Reset mid-ACCESS: enables drop asynchronously, no ack is generated, and the transfer is lost. The requester must re-issue it.

## Configuration
- MEM_BUS_ARB_RR_EN defined: round-robin arbitration. Search order starts at the requester after the last granted one (fetch -> rd -> wr -> fetch). The pointer updates on entry to ACCESS and resets to fetch, so the first grant after reset favors rd.
- Undefined: fixed priority fetch > rd > wr, no pointer register. Sustained fetch_req starves rd/wr.

## Test plan
- Single fetch, ROM_WAIT=1, rom_q=0xA5, fetch_addr=0x10: rom_en high 2 cycles with mem_addr=0x10; fetch_ack pulses 3 cycles after sampling edge with fetch_data=0xA5.
- Write, RAM_WAIT=2, wr_addr=0x20, wr_data=0x3C: ram_we high 3 cycles, mem_addr=0x20, mem_wdata=0x3C, then wr_ack 1 cycle; rd of 0x20 from a RAM model returns 0x3C.
- All three req high together, held after ack, default build: grant order fetch, fetch, fetch... and rd/wr never acked. With MEM_BUS_ARB_RR_EN: order rd, wr, fetch, rd.
- Assert reset during ACCESS of a rd: ram_re falls in the same cycle, no rd_ack, busy=0, and the next rd_req completes normally.
- rd_addr changed and rd_req dropped mid-ACCESS: mem_addr keeps the original value, and rd_ack still pulses once with data from the original address.
- ROM_WAIT=0 fetch: rom_en high exactly 1 cycle, ack 2 cycles after sampling edge.
